// File: rtl/task_word_unpacker.sv
// Word-buffer FIFO: registered push_rdy (not full), first-word-fall-through head.
// Write lands one cycle after push; push and pop may coincide at any level.
module task_word_unpacker_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [AW:0]      level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      level_nxt;
  logic             push;

  assign push      = push_vld && push_rdy;
  assign level     = wr_ptr - rd_ptr;
  assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);
  assign head_dat  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      push_rdy <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + (AW+1)'(push);
      rd_ptr   <= rd_ptr + (AW+1)'(pop);
      push_rdy <= (level_nxt != FULL_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// Unpacks buffered words into OUT_WIDTH symbols, LSB first; byte 0 visible the cycle after accept.
// Output holds under i_ready=0; o_ready drops only when the word FIFO is full.
module task_word_unpacker #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [IN_WIDTH-1:0]           i_data,
  input  logic [IN_WIDTH/OUT_WIDTH-1:0] i_keep,
  input  logic                          i_valid,
  input  logic                          i_last,
  output logic                          o_ready,
  output logic [OUT_WIDTH-1:0]          o_data,
  output logic                          o_valid,
  output logic                          o_first,
  output logic                          o_last,
  input  logic                          i_ready,
  output logic                          o_err,
  output logic [31:0]                   o_byte_count
);
  localparam int N  = IN_WIDTH / OUT_WIDTH;
  localparam int IW = $clog2(N);
  localparam int LW = $clog2(FIFO_DEPTH);
  localparam logic [IW:0] ONE_SYM = (IW+1)'(1);
  localparam logic [LW:0] ONE_LVL = (LW+1)'(1);

  typedef struct packed {
    logic                 last;
    logic [N-1:0]         keep;
    logic [IN_WIDTH-1:0]  data;
  } word_t;

  typedef enum logic {IDLE, EMIT} state_t;

  // Symbols on a last word: leading run of ones in keep, never fewer than one.
  function automatic logic [IW:0] keep_len(input logic [N-1:0] keep);
    logic        run;
    logic [IW:0] len;
    run = 1'b1;
    len = '0;
    for (int i = 0; i < N; i++) begin
      run = run & keep[i];
      if (run) len = (IW+1)'(i + 1);
    end
    if (len == '0) len = ONE_SYM;
    return len;
  endfunction

  function automatic logic keep_bad(input logic [N-1:0] keep);
    logic [N-1:0] mask;
    logic [IW:0]  len;
    len = keep_len(keep);
    for (int i = 0; i < N; i++) mask[i] = ((IW+1)'(i) < len);
    return keep != mask;
  endfunction

  state_t                      state;
  word_t                       in_word;
  word_t                       head;
  logic [$bits(word_t)-1:0]    head_dat;
  logic [N-1:0][OUT_WIDTH-1:0] lanes;
  logic [LW:0]                 level;
  logic [IW-1:0]               idx;
  logic [IW:0]                 sym_len;
  logic                        first_pend;
  logic                        err_done;
  logic                        final_sym;
  logic                        push;
  logic                        xfer;
  logic                        pop;

  assign in_word = '{last: i_last, keep: i_keep, data: i_data};

  task_word_unpacker_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .push_vld (i_valid),
    .push_rdy (o_ready),
    .push_dat (in_word),
    .pop      (pop),
    .head_dat (head_dat),
    .level    (level)
  );

  assign head      = word_t'(head_dat);
  assign lanes     = head.data;
  assign sym_len   = head.last ? keep_len(head.keep) : (IW+1)'(N);
  assign final_sym = ({1'b0, idx} == (sym_len - ONE_SYM));

  assign push = i_valid && o_ready;
  assign xfer = o_valid && i_ready;
  assign pop  = xfer && final_sym;

  assign o_valid = (state == EMIT);
  assign o_data  = o_valid ? lanes[idx] : '0;
  assign o_first = o_valid && first_pend;
  assign o_last  = o_valid && head.last && final_sym;
  // err_done keeps the pulse to one cycle even if the bad word stalls at the head.
  assign o_err   = o_valid && head.last && keep_bad(head.keep) && !err_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      first_pend   <= 1'b1;
      err_done     <= 1'b0;
      o_byte_count <= '0;
    end else begin
      case (state)
        IDLE:    if (push) state <= EMIT;
        EMIT:    if (pop && !push && (level == ONE_LVL)) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (pop)       idx <= '0;
      else if (xfer) idx <= idx + IW'(1);

      if (xfer) begin
        first_pend   <= o_last;
        o_byte_count <= o_first ? 32'd1 : o_byte_count + 32'd1;
      end

      if (pop)        err_done <= 1'b0;
      else if (o_err) err_done <= 1'b1;
    end
  end
endmodule

// File: doc/task_word_unpacker.md
TASK_WORD_UNPACKER -- requirements
Module: task_word_unpacker

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, meaning input word width in bits (multiple of OUT_WIDTH).
REQ-002 SHALL have parameter OUT_WIDTH, default 8, meaning output symbol width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning input word buffer depth (power of 2, >=2).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-005 i_clk  input  1  clock; all logic on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_data  input  IN_WIDTH  input word; byte 0 = bits [OUT_WIDTH-1:0].
REQ-008 i_keep  input  IN_WIDTH/OUT_WIDTH  valid-byte mask; sampled only on last word.
REQ-009 i_valid  input  1  input word valid.
REQ-010 i_last  input  1  word is last of packet.
REQ-011 o_ready  output  1  block can accept a word.
REQ-012 o_data  output  OUT_WIDTH  output symbol.
REQ-013 o_valid  output  1  output symbol valid.
REQ-014 o_first  output  1  symbol is first of packet.
REQ-015 o_last  output  1  symbol is last of packet.
REQ-016 i_ready  input  1  downstream accepts symbol.
REQ-017 o_err  output  1  one-cycle pulse: malformed keep on last word.
REQ-018 o_byte_count  output  32  symbols emitted in current packet, including the current accepted symbol.

Function
REQ-019 Input word SHALL be accepted on a rising edge with i_valid && o_ready; output symbol SHALL transfer on i_valid-style handshake o_valid && i_ready.
REQ-020 Accepted words (data, keep, last) SHALL be stored in a FIFO_DEPTH-entry FIFO; o_ready = FIFO not full (registered, no combinational path from i_ready).
REQ-021 Push and pop in the same cycle SHALL be supported at any fill level except push when full (o_ready=0 blocks it).
REQ-022 Unpack FSM SHALL have states IDLE (FIFO empty, o_valid=0) and EMIT (symbol of head word presented); IDLE->EMIT when FIFO non-empty; EMIT->IDLE after final symbol of head word transfers and FIFO is otherwise empty; else stay EMIT and advance to next word without bubble.
REQ-023 Latency SHALL be 1 cycle: word accepted at edge t into an empty block -> o_valid=1 with byte 0 after edge t.
REQ-024 Throughput SHALL be one symbol per cycle while i_ready=1; byte index advances 0..N-1 LSB first.
REQ-025 Non-last words SHALL emit all IN_WIDTH/OUT_WIDTH symbols regardless of i_keep.
REQ-026 Last word SHALL emit K symbols, K = number of contiguous ones in i_keep starting at bit 0; o_last=1 on symbol K-1.
REQ-027 If last-word i_keep[0]=0, K SHALL be 1 and o_err SHALL pulse for one cycle when that word reaches the FIFO head; non-contiguous keep (e.g. 4'b1011) SHALL truncate to K (=2) and pulse o_err.
REQ-028 o_first SHALL be 1 on the first symbol after reset and on the first symbol after any symbol with o_last=1.
REQ-029 While o_valid=1 && i_ready=0, o_data/o_first/o_last SHALL hold stable.
REQ-030 o_byte_count SHALL increment on each symbol transfer, reset to 1 on transfer of a symbol with o_first=1, and wrap modulo 2^32.
REQ-031 A single-word packet with K=1 SHALL produce one symbol with o_first=o_last=1.

Reset
REQ-032 i_rst_n low SHALL asynchronously clear FIFO pointers, FSM to IDLE, byte index to 0, first-pending flag to 1.
REQ-033 During and after reset: o_valid=0, o_ready=0 during reset then 1 on first edge after release, o_first=0, o_last=0, o_err=0, o_data=0, o_byte_count=0.
REQ-034 Reset mid-packet SHALL discard all buffered words; next accepted symbol SHALL carry o_first=1.

Verification
REQ-035 Word 0x44332211, last=1, keep=4'hF, i_ready=1 -> symbols 11,22,33,44 on 4 consecutive cycles, first on 11, last on 44, count 1..4.
REQ-036 Two words 0xDDCCBBAA (last=0), 0x00002211 (last=1, keep=4'b0011) -> AA,BB,CC,DD,11,22 back-to-back, last only on 22.
REQ-037 i_ready=0 with 5 words offered -> o_ready drops after 4 accepted; output holds byte 0; release -> all 20 bytes in order, no loss.
REQ-038 Last word keep=4'b0000 -> one symbol, o_first=o_last=1, o_err pulses once; keep=4'b1011 -> 2 symbols, o_err pulses.
REQ-039 Assert i_rst_n=0 after byte 1 of a 3-word packet -> o_valid=0 immediately; new packet after release starts with o_first=1, count=1.
